// File: rtl/mpu_load_ctrl.sv
// rtl/mpu_load_ctrl.sv - mem_load stream to row-major reg_load writes for the matrix register file
// Optional: define MPU_LOAD_ZERO_FILL_EN to zero the unloaded part of the MxN register after each load.
module mpu_load_ctrl #(
  parameter int M               = 4,
  parameter int N               = 4,
  parameter int FPBITS          = 31,
  parameter int MBITS           = 2,
  parameter int NBITS           = 2,
  parameter int MATRIX_REG_BITS = 3,
  parameter int LOAD_LAT        = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_en,
  input  logic [MBITS:0]             mem_m_load_size,
  input  logic [NBITS:0]             mem_n_load_size,
  input  logic [MATRIX_REG_BITS:0]   mem_load_addr,
  input  logic [FPBITS:0]            mem_load_element,
  output logic                       mem_load_ack,
  output logic                       mem_load_error,
  output logic                       reg_load_en,
  output logic [MATRIX_REG_BITS:0]   reg_load_addr,
  output logic [FPBITS:0]            reg_load_element,
  output logic [MBITS:0]             reg_i_load_loc,
  output logic [NBITS:0]             reg_j_load_loc,
  output logic [MBITS:0]             reg_m_load_size,
  output logic [NBITS:0]             reg_n_load_size,
  output logic                       load_busy,
  output logic                       load_done
);

  localparam int ECW = $clog2(M * N + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_FIN   = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;
`ifdef MPU_LOAD_ZERO_FILL_EN
  localparam logic [2:0] S_ZFILL = 3'd5;
`endif

  localparam logic [MBITS:0] M_L   = (MBITS + 1)'(M);
  localparam logic [NBITS:0] N_L   = (NBITS + 1)'(N);
  localparam logic [MBITS:0] M_ONE = (MBITS + 1)'(1);
  localparam logic [NBITS:0] N_ONE = (NBITS + 1)'(1);
  localparam logic [1:0]     W_END = 2'(LOAD_LAT);

  logic [2:0]     state;
  logic [1:0]     wait_cnt;
  logic [ECW-1:0] elem_cnt;
  logic [MBITS:0] i_cnt;
  logic [NBITS:0] j_cnt;
  logic           wait_release;
  logic [ECW-1:0] total;
  logic           bad_req;
  logic           last_j;

  assign total   = ECW'(reg_m_load_size) * ECW'(reg_n_load_size);
  assign last_j  = (j_cnt == reg_n_load_size - N_ONE);
  assign bad_req = (mem_m_load_size == '0) || (mem_n_load_size == '0) ||
                   (mem_m_load_size > M_L) || (mem_n_load_size > N_L);

  assign load_busy = (state != S_IDLE);
  assign load_done = (state == S_FIN);

`ifdef MPU_LOAD_ZERO_FILL_EN
  // Walk only the locations outside m x n: rows below m contribute columns n..N-1, the rest whole rows.
  logic [MBITS:0] zf_i_next;
  logic [NBITS:0] zf_j_next;
  logic           zf_last;
  logic           full_load;

  assign zf_last   = (i_cnt == M_L - M_ONE) && (j_cnt == N_L - N_ONE);
  assign full_load = (reg_m_load_size == M_L) && (reg_n_load_size == N_L);

  always_comb begin
    zf_i_next = i_cnt;
    zf_j_next = j_cnt + N_ONE;
    if (j_cnt == N_L - N_ONE) begin
      zf_i_next = i_cnt + M_ONE;
      zf_j_next = ((i_cnt + M_ONE) < reg_m_load_size) ? reg_n_load_size : '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      wait_cnt         <= '0;
      elem_cnt         <= '0;
      i_cnt            <= '0;
      j_cnt            <= '0;
      wait_release     <= 1'b0;
      mem_load_ack     <= 1'b0;
      mem_load_error   <= 1'b0;
      reg_load_en      <= 1'b0;
      reg_load_addr    <= '0;
      reg_load_element <= '0;
      reg_i_load_loc   <= '0;
      reg_j_load_loc   <= '0;
      reg_m_load_size  <= '0;
      reg_n_load_size  <= '0;
    end else begin
      mem_load_error <= 1'b0;
      reg_load_en    <= 1'b0;
      // A completed load leaves load_en high; a new request needs it to drop first.
      if (!load_en) wait_release <= 1'b0;

      case (state)
        S_IDLE: begin
          if (load_en && !wait_release) begin
            reg_m_load_size <= mem_m_load_size;
            reg_n_load_size <= mem_n_load_size;
            reg_load_addr   <= mem_load_addr;
            wait_release    <= 1'b1;
            wait_cnt        <= '0;
            elem_cnt        <= '0;
            i_cnt           <= '0;
            j_cnt           <= '0;
            if (bad_req) begin
              state          <= S_ERR;
              mem_load_error <= 1'b1;
            end else begin
              state        <= S_WAIT;
              mem_load_ack <= 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (!load_en) begin
            state        <= S_IDLE;
            mem_load_ack <= 1'b0;
          end else if (wait_cnt == W_END) begin
            state <= S_XFER;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end

        S_XFER: begin
          if (!load_en) begin
            state        <= S_IDLE;
            mem_load_ack <= 1'b0;
          end else begin
            reg_load_en      <= 1'b1;
            reg_load_element <= mem_load_element;
            reg_i_load_loc   <= i_cnt;
            reg_j_load_loc   <= j_cnt;
            if (elem_cnt == total - ECW'(1)) begin
              mem_load_ack <= 1'b0;
`ifdef MPU_LOAD_ZERO_FILL_EN
              if (full_load) begin
                state <= S_FIN;
              end else begin
                state <= S_ZFILL;
                i_cnt <= (reg_n_load_size < N_L) ? '0 : reg_m_load_size;
                j_cnt <= (reg_n_load_size < N_L) ? reg_n_load_size : '0;
              end
`else
              state <= S_FIN;
`endif
            end else begin
              elem_cnt <= elem_cnt + ECW'(1);
              if (last_j) begin
                j_cnt <= '0;
                i_cnt <= i_cnt + M_ONE;
              end else begin
                j_cnt <= j_cnt + N_ONE;
              end
            end
          end
        end

`ifdef MPU_LOAD_ZERO_FILL_EN
        S_ZFILL: begin
          reg_load_en      <= 1'b1;
          reg_load_element <= '0;
          reg_i_load_loc   <= i_cnt;
          reg_j_load_loc   <= j_cnt;
          if (zf_last) begin
            state <= S_FIN;
          end else begin
            i_cnt <= zf_i_next;
            j_cnt <= zf_j_next;
          end
        end
`endif

        S_FIN: state <= S_IDLE;

        S_ERR: begin
          if (!load_en) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_load_ctrl.sv
// tb/tb_mpu_load_ctrl.sv - scoreboard bench for mpu_load_ctrl, two lanes with LOAD_LAT 0 and 2
module tb_mpu_load_ctrl;
  localparam int M = 4;
  localparam int N = 4;

  typedef struct packed {
    logic [2:0]  i;
    logic [2:0]  j;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] fval(input int k);
    case (k)
      0: return 32'h3F80_0000;  1: return 32'h4000_0000;
      2: return 32'h4040_0000;  3: return 32'h4080_0000;
      4: return 32'h40A0_0000;  5: return 32'h40C0_0000;
      6: return 32'h40E0_0000;  7: return 32'h4100_0000;
      8: return 32'h4110_0000;  9: return 32'h4120_0000;
      10: return 32'h4130_0000; 11: return 32'h4140_0000;
      12: return 32'h4150_0000; 13: return 32'h4160_0000;
      14: return 32'h4170_0000; 15: return 32'h4180_0000;
      default: return 32'h0;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = 2 * g;

    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic [2:0]  msz = '0;
    logic [2:0]  nsz = '0;
    logic [3:0]  addr = '0;
    logic [31:0] elem = '0;
    logic        ack, err, wen, busy, done;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  wi, wj, wm, wn;

    mpu_load_ctrl #(.LOAD_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .load_en(load_en),
      .mem_m_load_size(msz), .mem_n_load_size(nsz),
      .mem_load_addr(addr), .mem_load_element(elem),
      .mem_load_ack(ack), .mem_load_error(err),
      .reg_load_en(wen), .reg_load_addr(waddr), .reg_load_element(wdata),
      .reg_i_load_loc(wi), .reg_j_load_loc(wj),
      .reg_m_load_size(wm), .reg_n_load_size(wn),
      .load_busy(busy), .load_done(done)
    );

    wr_t  exp_q[$];
    int   done_cnt = 0;
    int   err_cnt = 0;
    logic [3:0] cur_addr = '0;
    bit   fin = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL lat%0d %s: got %0h expected %0h", LAT, name, act, exp);
      end
    endtask

    // Monitor: every register-file write is popped against the scoreboard.
    always @(negedge clk) begin
      if (rst) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (wen) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {wi, wj, wdata}, 64'h0);
          end else begin
            chk("write_ij_data", {wi, wj, wdata}, exp_q.pop_front());
            chk("write_addr", waddr, cur_addr);
          end
        end
      end
    end

    // mode 0: full load, 1: drop load_en after stop_at captures, 2: reset after stop_at captures
    task automatic run_load(input int m, input int n, input int a, input int mode, input int stop_at);
      int  acnt, ack_cyc, cap, base_done, base_err, ecount;
      bit  seen, bad, late_ack;
      wr_t w;
      bad = (m == 0 || n == 0 || m > M || n > N);
      ecount = (mode == 0) ? m * n : stop_at;
      cur_addr = 4'(a);
      if (!bad) begin
        for (int k = 0; k < ecount; k++) begin
          w.i = 3'(k / n); w.j = 3'(k % n); w.d = fval(k);
          exp_q.push_back(w);
        end
`ifdef MPU_LOAD_ZERO_FILL_EN
        if (mode == 0)
          for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
              if (i >= m || j >= n) begin
                w.i = 3'(i); w.j = 3'(j); w.d = 32'h0;
                exp_q.push_back(w);
              end
`endif
      end
      base_done = done_cnt;
      base_err = err_cnt;
      @(negedge clk);
      msz = 3'(m); nsz = 3'(n); addr = 4'(a); load_en = 1'b1; elem = 32'hDEAD_BEEF;
      seen = 1'b0; acnt = 0; ack_cyc = 0; cap = -1;
      for (int c = 0; c < 120; c++) begin
        @(posedge clk); #1;
        if (ack) begin
          acnt = seen ? acnt + 1 : 0;
          seen = 1'b1;
          ack_cyc++;
        end
        cap = seen ? acnt - LAT - 1 : -1;
        elem = (cap >= 0) ? fval(cap) : 32'hDEAD_BEEF;
        if (bad && c == 9) break;
        if (!bad && mode == 0 && done) break;
        if (!bad && mode != 0 && cap == stop_at) break;
      end
      if (bad) begin
        @(negedge clk);
        chk("err_pulses", err_cnt - base_err, 1);
        chk("err_no_ack", seen, 0);
        chk("err_busy_held", busy, 1);
        load_en = 1'b0;
        @(posedge clk); #1;
        chk("err_busy_release", busy, 0);
      end else if (mode == 0) begin
        @(negedge clk); #1;
        chk("done_pulses", done_cnt - base_done, 1);
        chk("ack_cycles", ack_cyc, LAT + 1 + m * n);
        chk("size_latch", {wm, wn}, {3'(m), 3'(n)});
        late_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(posedge clk); #1;
          if (ack) late_ack = 1'b1;
        end
        chk("no_rerequest", late_ack, 0);
        load_en = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
      end else if (mode == 1) begin
        load_en = 1'b0;
        @(posedge clk); #1;
        chk("abort_ack", ack, 0);
        chk("abort_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - base_done, 0);
      end else begin
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        chk("reset_outputs", {ack, err, wen, waddr, wdata, wi, wj, wm, wn, busy, done}, 64'h0);
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("reset_no_done", done_cnt - base_done, 0);
      end
      @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      exp_q.delete();
    endtask

    initial begin
      repeat (2) @(negedge clk);
      #1;
      chk("reset_state", {ack, err, wen, waddr, wdata, wi, wj, wm, wn, busy, done}, 64'h0);
      @(negedge clk);
      rst = 1'b1;
      run_load(2, 3, 5, 0, 0);
      run_load(4, 4, 3, 0, 0);
      run_load(0, 3, 1, 0, 0);
      run_load(5, 1, 2, 0, 0);
      run_load(3, 3, 6, 1, 4);
      run_load(1, 1, 7, 0, 0);
      run_load(4, 4, 2, 2, 5);
      run_load(2, 2, 4, 0, 0);
      run_load(4, 1, 0, 0, 0);
      fin = 1'b1;
    end
  end

  initial begin
    fork
      wait (lane[0].fin && lane[1].fin);
      begin
        #200000;
        failures++;
        $display("FAIL timeout: lanes done %0d %0d expected 1 1", lane[0].fin, lane[1].fin);
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
